// File: rtl/pipe_stage_reg_pkg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg_pkg
//   Shared definitions for the generic pipeline stage register.
//   - ps_state_e : occupancy state of a stage (EMPTY / HALF / FULL)
//   - PC_INIT    : program counter value that stages place in the pc field
//                  of their RESET_DATA bubble payload
//   - ZERO_WORD  : 32-bit zero constant for packing payload fields
//   - ps_can_accept() : whether a stage in a given state can take a beat
// -----------------------------------------------------------------------------
package pipe_stage_reg_pkg;

    typedef enum logic [1:0] {
        PS_EMPTY = 2'b00,   // no beat held
        PS_HALF  = 2'b01,   // main register holds a beat
        PS_FULL  = 2'b10    // main and skid registers both hold beats
    } ps_state_e;

    localparam logic [31:0] PC_INIT   = 32'h0000_0000;
    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    // The skid entry exists so that acceptance depends only on stored state.
    function automatic logic ps_can_accept(input ps_state_e state);
        return (state != PS_FULL);
    endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg_if
//   One valid/ready payload channel between pipeline stages.
//   Signals:
//     valid : producer has a beat
//     ready : consumer accepts the beat this cycle
//     data  : DATA_W-bit payload bundle
//   Modports:
//     master : producer side (drives valid/data, samples ready)
//     slave  : consumer side (samples valid/data, drives ready)
// -----------------------------------------------------------------------------
interface pipe_stage_reg_if #(
    parameter int DATA_W = 70
) ();

    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;

    modport master (
        output valid,
        output data,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        output ready
    );

endinterface

// File: rtl/pipe_stat_cnt.sv
// -----------------------------------------------------------------------------
// pipe_stat_cnt
//   Saturating event counter for pipeline statistics.
//   Ports:
//     clk   in   clock
//     rst   in   asynchronous active-high reset (clears the count)
//     i_clr in   synchronous clear, wins over i_inc in the same cycle
//     i_inc in   count one qualifying cycle
//     o_cnt out  CNT_W-bit count, sticks at all-ones
// -----------------------------------------------------------------------------
module pipe_stat_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + CNT_ONE;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
//   Generic pipeline stage register: one payload beat per cycle under a
//   valid/ready handshake, 1-cycle latency, full throughput. A two-entry
//   (main + skid) store lets in_ready come straight from registered state.
//   Synchronous flush kills all held beats; RESET_DATA is the bubble payload.
//
//   Optional feature (macro PIPE_STAT_EN): stall/bubble statistics counters.
//   Without the macro the counter outputs are tied to zero and i_stat_clr is
//   ignored; the ports exist in both builds.
//
//   Ports:
//     clk          in   clock, rising edge
//     rst          in   asynchronous active-high reset
//     i_flush      in   synchronous flush, highest priority
//     s_in         slave  upstream channel  (valid, ready, data)
//     m_out        master downstream channel (valid, ready, data = main reg)
//     i_stat_clr   in   synchronous clear of statistics counters
//     o_stall_cnt  out  cycles with out_valid & !out_ready
//     o_bubble_cnt out  cycles with out_ready & !out_valid
// -----------------------------------------------------------------------------
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int                 DATA_W     = 70,
    parameter logic [DATA_W-1:0]  RESET_DATA = '0,
    parameter bit                 FLUSH_CLR  = 1'b1,
    parameter int                 CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_flush,
    pipe_stage_reg_if.slave       s_in,
    pipe_stage_reg_if.master      m_out,
    input  logic                  i_stat_clr,
    output logic [CNT_W-1:0]      o_stall_cnt,
    output logic [CNT_W-1:0]      o_bubble_cnt
);

    ps_state_e         r_state;
    ps_state_e         w_state_next;
    logic [DATA_W-1:0] r_main;
    logic [DATA_W-1:0] w_main_next;
    logic [DATA_W-1:0] r_skid;
    logic [DATA_W-1:0] w_skid_next;

    logic w_in_ready;
    logic w_out_valid;
    logic w_in_fire;
    logic w_out_fire;

    // Both handshake outputs depend only on r_state, so no input reaches them
    // combinationally.
    assign w_in_ready  = ps_can_accept(r_state);
    assign w_out_valid = (r_state != PS_EMPTY);
    assign w_in_fire   = s_in.valid & w_in_ready;
    assign w_out_fire  = w_out_valid & m_out.ready;

    assign s_in.ready  = w_in_ready;
    assign m_out.valid = w_out_valid;
    assign m_out.data  = r_main;

    // State register and payload storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= PS_EMPTY;
            r_main  <= RESET_DATA;
            r_skid  <= RESET_DATA;
        end else begin
            r_state <= w_state_next;
            r_main  <= w_main_next;
            r_skid  <= w_skid_next;
        end
    end

    // Next-state and datapath steering.
    always_comb begin
        w_state_next = r_state;
        w_main_next  = r_main;
        w_skid_next  = r_skid;

        if (i_flush) begin
            // Any beat accepted this cycle is dropped; a beat leaving this
            // cycle has already been delivered downstream.
            w_state_next = PS_EMPTY;
            if (FLUSH_CLR) begin
                w_main_next = RESET_DATA;
                w_skid_next = RESET_DATA;
            end
        end else begin
            unique case (r_state)
                PS_EMPTY: begin
                    if (w_in_fire) begin
                        w_state_next = PS_HALF;
                        w_main_next  = s_in.data;
                    end
                end
                PS_HALF: begin
                    if (w_in_fire && w_out_fire) begin
                        w_main_next = s_in.data;
                    end else if (w_in_fire) begin
                        // Downstream stalled: park the new beat in the skid.
                        w_state_next = PS_FULL;
                        w_skid_next  = s_in.data;
                    end else if (w_out_fire) begin
                        w_state_next = PS_EMPTY;
                    end
                end
                PS_FULL: begin
                    // in_ready is low here, so no input is taken.
                    if (w_out_fire) begin
                        w_state_next = PS_HALF;
                        w_main_next  = r_skid;
                    end
                end
                default: begin
                    w_state_next = PS_EMPTY;
                end
            endcase
        end
    end

`ifdef PIPE_STAT_EN
    // Index 0: stall counter, index 1: bubble counter.
    logic             w_stat_inc [2];
    logic [CNT_W-1:0] w_stat_cnt [2];

    assign w_stat_inc[0] = w_out_valid & ~m_out.ready;
    assign w_stat_inc[1] = m_out.ready & ~w_out_valid;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_stat
            pipe_stat_cnt #(
                .CNT_W (CNT_W)
            ) u_cnt (
                .clk   (clk),
                .rst   (rst),
                .i_clr (i_stat_clr),
                .i_inc (w_stat_inc[gi]),
                .o_cnt (w_stat_cnt[gi])
            );
        end
    endgenerate

    assign o_stall_cnt  = w_stat_cnt[0];
    assign o_bubble_cnt = w_stat_cnt[1];
`else
    logic w_unused_stat_clr;
    assign w_unused_stat_clr = i_stat_clr;
    assign o_stall_cnt       = '0;
    assign o_bubble_cnt      = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_reg
//   Self-checking bench for pipe_stage_reg. The reference model is a FIFO
//   queue of at most two beats plus a "last payload shown" value and two
//   saturating statistics counters.
// -----------------------------------------------------------------------------
module tb_pipe_stage_reg;

    localparam int DW = 70;
    localparam int CW = 4;
    localparam logic [DW-1:0] RST_VAL = 70'h3_1234_5678_9ABC_DEF0;
    localparam int CMAX = (1 << CW) - 1;
`ifdef PIPE_STAT_EN
    localparam bit STAT_ON = 1'b1;
`else
    localparam bit STAT_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          stat_clr;
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] bubble_cnt;

    pipe_stage_reg_if #(.DATA_W(DW)) up_if ();
    pipe_stage_reg_if #(.DATA_W(DW)) dn_if ();

    always #5 clk = ~clk;

    pipe_stage_reg #(
        .DATA_W     (DW),
        .RESET_DATA (RST_VAL),
        .FLUSH_CLR  (1'b1),
        .CNT_W      (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_flush      (flush),
        .s_in         (up_if.slave),
        .m_out        (dn_if.master),
        .i_stat_clr   (stat_clr),
        .o_stall_cnt  (stall_cnt),
        .o_bubble_cnt (bubble_cnt)
    );

    int n_vec;
    int n_err;

    // Reference model state.
    logic [DW-1:0] mq[$];
    logic [DW-1:0] m_idle;
    int            m_stall;
    int            m_bubble;

    task automatic check_val(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_idle   = RST_VAL;
        m_stall  = 0;
        m_bubble = 0;
    endtask

    task automatic check_outputs();
        check_val("in_ready",   up_if.ready, (mq.size() < 2));
        check_val("out_valid",  dn_if.valid, (mq.size() > 0));
        check_val("out_data",   dn_if.data,  (mq.size() > 0) ? mq[0] : m_idle);
        check_val("stall_cnt",  stall_cnt,   STAT_ON ? m_stall  : 0);
        check_val("bubble_cnt", bubble_cnt,  STAT_ON ? m_bubble : 0);
    endtask

    function automatic logic [DW-1:0] rand_word();
        logic [95:0] w;
        w = {$urandom, $urandom, $urandom};
        return w[DW-1:0];
    endfunction

    // Called at a falling edge: check, drive one cycle of inputs, advance the
    // model across the rising edge, return at the next falling edge.
    task automatic step(input logic iv, input logic [DW-1:0] id, input logic ordy,
                        input logic fl, input logic sc);
        bit in_f;
        bit out_f;
        bit st;
        bit bu;
        check_outputs();
        up_if.valid = iv;
        up_if.data  = id;
        dn_if.ready = ordy;
        flush       = fl;
        stat_clr    = sc;
        @(posedge clk);
        in_f  = iv && (mq.size() < 2);
        out_f = ordy && (mq.size() > 0);
        st    = (mq.size() > 0) && !ordy;
        bu    = ordy && (mq.size() == 0);
        if (sc) begin
            m_stall  = 0;
            m_bubble = 0;
        end else begin
            if (st && m_stall  < CMAX) m_stall++;
            if (bu && m_bubble < CMAX) m_bubble++;
        end
        if (fl) begin
            mq.delete();
            m_idle = RST_VAL;
        end else begin
            if (out_f) m_idle = mq.pop_front();
            if (in_f)  mq.push_back(id);
        end
        @(negedge clk);
    endtask

    initial begin
        n_vec       = 0;
        n_err       = 0;
        rst         = 1'b1;
        flush       = 1'b0;
        stat_clr    = 1'b0;
        up_if.valid = 1'b0;
        up_if.data  = '0;
        dn_if.ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        model_reset();
        check_outputs();
        rst = 1'b0;

        // Bubbles right after reset: downstream ready, nothing arriving.
        repeat (5) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check_val("bubble_after_5", bubble_cnt, STAT_ON ? 5 : 0);

        // Streaming 1,2,3... at full rate.
        for (int i = 1; i <= 10; i++) step(1'b1, DW'(i), 1'b1, 1'b0, 1'b0);
        repeat (2) step(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // Stall: A, B taken, C refused; release drains A then B.
        step(1'b1, 70'hA, 1'b0, 1'b0, 1'b0);
        step(1'b1, 70'hB, 1'b0, 1'b0, 1'b0);
        step(1'b1, 70'hC, 1'b0, 1'b0, 1'b0);
        check_val("stall_hold_A", dn_if.data, 70'hA);
        check_val("stall_in_ready", up_if.ready, 1'b0);
        repeat (3) step(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // Flush while FULL with D offered; D must never appear.
        step(1'b1, 70'h11, 1'b0, 1'b0, 1'b0);
        step(1'b1, 70'h22, 1'b0, 1'b0, 1'b0);
        step(1'b1, 70'hD, 1'b0, 1'b1, 1'b0);
        check_val("flush_out_valid", dn_if.valid, 1'b0);
        check_val("flush_out_data", dn_if.data, RST_VAL);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        // Flush in FULL with a delivery in the same cycle.
        step(1'b1, 70'h33, 1'b0, 1'b0, 1'b0);
        step(1'b1, 70'h44, 1'b0, 1'b0, 1'b0);
        step(1'b1, 70'h55, 1'b1, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // Long stall saturates the stall counter, then clear it.
        step(1'b1, 70'h77, 1'b0, 1'b0, 1'b0);
        repeat (20) step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        check_val("stall_saturated", stall_cnt, STAT_ON ? 15 : 0);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        check_val("stall_cleared", stall_cnt, 0);
        repeat (2) step(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset pulse between edges while FULL.
        step(1'b1, 70'h88, 1'b0, 1'b0, 1'b0);
        step(1'b1, 70'h99, 1'b0, 1'b0, 1'b0);
        check_outputs();
        up_if.valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check_val("arst_out_valid", dn_if.valid, 1'b0);
        check_val("arst_out_data",  dn_if.data,  RST_VAL);
        check_val("arst_in_ready",  up_if.ready, 1'b1);
        check_val("arst_stall_cnt", stall_cnt,   0);
        #1 rst = 1'b0;
        model_reset();
        @(negedge clk);

        // Randomized traffic including flushes and counter clears.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, rand_word(), $urandom_range(0, 9) < 6,
                 $urandom_range(0, 15) == 0, $urandom_range(0, 31) == 0);
        end
        repeat (3) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check_outputs();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
